// File: rtl/sb_pkg.sv
// Shared types and constants for the store buffer slice.
package sb_pkg;
  localparam int SB_DEPTH_DFLT = 4;
  // Low address bits below this index select a byte within a word and are
  // ignored when matching loads against buffered stores.
  localparam int WORD_LSB      = 2;
  localparam int SB_AW         = 32;
  localparam int SB_DW         = 32;

  typedef struct packed {
    logic [SB_AW-1:0] addr;
    logic [SB_DW-1:0] data;
  } sb_entry_t;
endpackage

// File: rtl/store_buffer_if.sv
// Memory-side port of the store buffer: write drain handshake plus the
// combinational read path used for loads that miss the buffer.
interface store_buffer_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [AW-1:0] mem_raddr;
  logic [DW-1:0] mem_rdata;

  modport master (
    output mem_req, mem_addr, mem_wdata, mem_raddr,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_addr, mem_wdata, mem_raddr,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/sb_match.sv
// Word-address match of a load against all valid buffered stores; returns
// the slot of the youngest matching entry.
module sb_match
  import sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH_DFLT,
  parameter int AW    = 32,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]         valid,
  input  logic [DEPTH-1:0][AW-1:0] addrs,
  input  logic [PW-1:0]            head,
  input  logic [AW-1:0]            cpu_addr,
  output logic                     hit,
  output logic [PW-1:0]            idx
);
  logic [DEPTH-1:0] match;

  for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
    assign match[g] = valid[g] && ((addrs[g] >> WORD_LSB) == (cpu_addr >> WORD_LSB));
  end

  // Walk slots oldest->youngest starting at head; the last hit wins.
  always_comb begin
    hit = 1'b0;
    idx = head;
    for (int k = 0; k < DEPTH; k++) begin
      if (match[head + PW'(k)]) begin
        hit = 1'b1;
        idx = head + PW'(k);
      end
    end
  end
endmodule

// File: rtl/store_buffer.sv
// Store buffer between a single-cycle CPU and memory: stores are queued in a
// circular FIFO and drained in order; loads are forwarded from the youngest
// matching buffered store, otherwise served from memory.
module store_buffer
  import sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH_DFLT,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cpu_we,
  input  logic [AW-1:0]          cpu_addr,
  input  logic [DW-1:0]          cpu_wdata,
  output logic [DW-1:0]          cpu_rdata,
  output logic                   cpu_full,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] count,
  store_buffer_if.master         mem
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][AW-1:0] addr_q;
  logic [DEPTH-1:0][DW-1:0] data_q;
  logic [PW-1:0]            head_q, tail_q;
  logic [CW-1:0]            cnt_q;
  logic                     ovf_q;
  logic                     full, push, pop;
  logic [DEPTH-1:0]         valid;
  logic                     hit;
  logic [PW-1:0]            hit_idx;

  assign full = (cnt_q == CW'(DEPTH));
  // Pop only when something is presented, so a stray ack is ignored.
  assign pop  = mem.mem_req && mem.mem_ack;
  // A pop in the same cycle frees the slot, so a full buffer still accepts.
  assign push = cpu_we && (!full || pop);

  // Slot i is valid when its distance from head is below the occupancy.
  always_comb begin
    valid = '0;
    for (int i = 0; i < DEPTH; i++)
      valid[i] = CW'(PW'(PW'(i) - head_q)) < cnt_q;
  end

  // Pointer, occupancy and sticky overflow state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push) tail_q <= tail_q + PW'(1);
      if (pop)  head_q <= head_q + PW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (cpu_we && !push) ovf_q <= 1'b1;
    end
  end

  // Entry storage; validity comes from the pointers, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= cpu_addr;
      data_q[tail_q] <= cpu_wdata;
    end
  end

  sb_match #(.DEPTH(DEPTH), .AW(AW), .PW(PW)) u_match (
    .valid    (valid),
    .addrs    (addr_q),
    .head     (head_q),
    .cpu_addr (cpu_addr),
    .hit      (hit),
    .idx      (hit_idx)
  );

  assign cpu_rdata     = hit ? data_q[hit_idx] : mem.mem_rdata;
  assign cpu_full      = full;
  assign overflow      = ovf_q;
  assign count         = cnt_q;
  assign mem.mem_req   = (cnt_q != '0);
  assign mem.mem_addr  = addr_q[head_q];
  assign mem.mem_wdata = data_q[head_q];
  assign mem.mem_raddr = cpu_addr;
endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter: DEPTH, default 4, number of buffered stores; power of two, minimum 2.
REQ-002 Parameter: AW, default 32, byte-address width.
REQ-003 Parameter: DW, default 32, data word width.
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 cpu_we  input  1  processor store strobe (MemWrite).
REQ-007 cpu_addr  input  AW  processor byte address (DataAdr); same port for loads and stores.
REQ-008 cpu_wdata  input  DW  processor store data (WriteData).
REQ-009 cpu_rdata  output  DW  load data returned to the processor (ReadData).
REQ-010 cpu_full  output  1  buffer holds DEPTH entries.
REQ-011 overflow  output  1  sticky flag: a store was dropped.
REQ-012 count  output  $clog2(DEPTH)+1  number of valid entries.
REQ-013 mem_req  output  1  head entry presented to memory.
REQ-014 mem_addr  output  AW  head entry address.
REQ-015 mem_wdata  output  DW  head entry data.
REQ-016 mem_ack  input  1  memory accepted the head entry this cycle.
REQ-017 mem_raddr  output  AW  memory read address, always equal to cpu_addr.
REQ-018 mem_rdata  input  DW  memory read data, combinational from mem_raddr.

Function
REQ-019 Storage: circular FIFO of DEPTH {addr, data} entries with head and tail pointers that wrap modulo DEPTH, plus an occupancy counter.
REQ-020 Push: cpu_we=1 and not full enqueues {cpu_addr, cpu_wdata} at the tail on the next edge; count increments.
REQ-021 Pop: mem_req=1 and mem_ack=1 retires the head on the edge; count decrements.
REQ-022 Push and pop in the same cycle: both take effect and count is unchanged, including when the buffer is full (push accepted).
REQ-023 Push when full without a pop: the store is dropped, contents are unchanged, and overflow is set to 1 until reset.
REQ-024 mem_req = (count != 0), driven from registered state only; it is never combinationally dependent on cpu_we.
REQ-025 Latency: a push into an empty buffer raises mem_req on the cycle after the push edge; stores to memory never bypass the FIFO.
REQ-026 mem_addr and mem_wdata hold stable while mem_req=1 and mem_ack=0.
REQ-027 mem_ack while mem_req=0 is ignored.
REQ-028 Store-to-load forwarding: compare cpu_addr[AW-1:2] against all valid entries' addr[AW-1:2]. On any match, cpu_rdata = data of the youngest matching entry; otherwise cpu_rdata = mem_rdata. The path is purely combinational (single-cycle CPU).
REQ-029 Forwarding covers only entries valid before the current edge; a store issued in the same cycle is not forwarded.
REQ-030 Forwarding sees the head entry in its pop cycle (mem_ack=1) as still valid.
REQ-031 No coalescing: repeated stores to one address occupy separate entries and drain in program order.
REQ-032 cpu_full = (count == DEPTH).

Reset
REQ-033 Reset asynchronously clears head, tail and count to 0 and overflow to 0; mem_req drops to 0 immediately.
REQ-034 Reset mid-drain discards all pending entries; entry storage needs no reset because valid is derived from the pointers.
REQ-035 Released reset: the first push is accepted at the first rising edge with reset=0.

Structure
REQ-036 Shared package sb_pkg holds typedef sb_entry_t {addr, data} and constants SB_DEPTH_DFLT=4 and WORD_LSB=2.
REQ-037 One sub-module, sb_match: takes the valid mask, entry addresses, head pointer and cpu_addr; returns hit plus the youngest-match index.

Verification
REQ-038 Reset, then push [0x64]=7 with mem_ack=0 -> one cycle later mem_req=1, mem_addr=0x64, mem_wdata=7, count=1; a load of 0x64 with mem_rdata=0 returns 7.
REQ-039 Push [0x2E0]=1 then [0x2E0]=1024 with mem_ack=0 -> a load of 0x2E0 returns 1024; with mem_ack=1 the drain order is 1 then 1024.
REQ-040 Push 4 stores with mem_ack=0 -> cpu_full=1, count=4; a 5th push leaves count=4 and sets overflow=1, which persists after the FIFO drains.
REQ-041 Full buffer, then push and mem_ack in the same cycle -> count stays 4, the new entry is drained last, overflow stays 0; the test runs past a pointer wrap.
REQ-042 Assert reset with 3 entries pending -> mem_req=0 and count=0 without waiting for a clock edge; a later load of the pending address returns mem_rdata.
REQ-043 Load of 0x40 with no matching entry and mem_rdata=0xDEADBEEF -> cpu_rdata=0xDEADBEEF and mem_raddr=0x40 in the same cycle.
